// File: rtl/jtag_host.sv
// JTAG host controller: turns TAP-reset / IR / DR / idle-clock commands into
// TCK/TMS/TDI/TRST sequences on one system clock and returns captured TDO bits.
module jtag_host #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_type,
  input  logic [4:0]  cmd_len,
  input  logic [31:0] cmd_data,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        jtag_tck,
  output logic        jtag_tms,
  output logic        jtag_tdi,
  output logic        jtag_trst,
  input  logic        jtag_tdo
);

  localparam int unsigned   CW   = $clog2(2 * CLK_DIV + 1);
  localparam logic [CW-1:0] HALF = CW'(CLK_DIV);
  localparam logic [CW-1:0] FULL = CW'(2 * CLK_DIV);

  typedef enum logic [1:0] {AUTORST, IDLE, RUN, DONE} state_t;
  typedef enum logic [1:0] {
    CMD_RST = 2'd0,
    CMD_IR  = 2'd1,
    CMD_DR  = 2'd2,
    CMD_RTI = 2'd3
  } cmd_t;

  typedef struct packed {
    logic       tms;
    logic       trst;
    logic       shift;
    logic [4:0] bit_idx;
  } per_t;

  state_t        r_state;
  cmd_t          r_type;
  logic [4:0]    r_len;
  logic [31:0]   r_data;
  logic [31:0]   r_cap;
  logic [5:0]    r_per;
  logic [CW-1:0] r_cnt;
  logic          r_shift;
  logic [4:0]    r_idx;

  logic          w_start;
  logic          w_end;
  logic [5:0]    w_nper;
  logic [5:0]    w_last;
  per_t          w_nxt;

  // Pin values for period p of a command, counted from Run-Test/Idle.
  function automatic per_t period_info(cmd_t t, logic [4:0] len, logic [5:0] p);
    per_t       info;
    logic [5:0] off;
    logic [5:0] rel;
    info      = '0;
    info.trst = 1'b1;
    off       = (t == CMD_IR) ? 6'd4 : 6'd3;
    rel       = p - off;
    case (t)
      CMD_RST: begin
        info.tms  = (p < 6'd5);
        info.trst = (p >= 6'd5);
      end
      CMD_IR, CMD_DR: begin
        if (p < off) begin
          info.tms = (p == 6'd0) || ((t == CMD_IR) && (p == 6'd1));
        end else if (rel <= {1'b0, len}) begin
          info.shift   = 1'b1;
          info.bit_idx = rel[4:0];
          info.tms     = (rel[4:0] == len);
        end else begin
          info.tms = (rel == ({1'b0, len} + 6'd1));
        end
      end
      default: ;
    endcase
    return info;
  endfunction

  always_comb begin
    w_start = (r_cnt == '0) || (r_cnt == FULL);
    // r_cnt is 0 only before the first period; later boundaries advance r_per.
    w_nper  = (r_cnt == '0) ? r_per : r_per + 6'd1;
    case (r_type)
      CMD_RST: w_last = 6'd5;
      CMD_IR:  w_last = {1'b0, r_len} + 6'd6;
      CMD_DR:  w_last = {1'b0, r_len} + 6'd5;
      default: w_last = {1'b0, r_len};
    endcase
    w_end = (r_cnt == FULL) && (r_per == w_last);
    w_nxt = period_info(r_type, r_len, w_nper);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= AUTORST;
      r_type    <= CMD_RST;
      r_len     <= '0;
      r_data    <= '0;
      r_cap     <= '0;
      r_per     <= '0;
      r_cnt     <= '0;
      r_shift   <= 1'b0;
      r_idx     <= '0;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      jtag_tck  <= 1'b0;
      jtag_tms  <= 1'b1;
      jtag_tdi  <= 1'b0;
      jtag_trst <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE, DONE: begin
          rsp_valid <= 1'b0;
          if (cmd_valid) begin
            r_type    <= cmd_t'(cmd_type);
            r_len     <= cmd_len;
            r_data    <= cmd_data;
            r_cap     <= '0;
            r_per     <= '0;
            r_cnt     <= '0;
            cmd_ready <= 1'b0;
            r_state   <= RUN;
          end else begin
            r_state   <= IDLE;
          end
        end
        AUTORST, RUN: begin
          if (w_end) begin
            jtag_tck  <= 1'b0;
            jtag_tms  <= 1'b0;
            jtag_tdi  <= 1'b0;
            jtag_trst <= 1'b1;
            cmd_ready <= 1'b1;
            if (r_state == RUN) begin
              rsp_valid <= 1'b1;
              rsp_data  <= r_cap;
              r_state   <= DONE;
            end else begin
              r_state   <= IDLE;
            end
          end else if (w_start) begin
            jtag_tck  <= 1'b0;
            jtag_tms  <= w_nxt.tms;
            jtag_trst <= w_nxt.trst;
            jtag_tdi  <= w_nxt.shift & r_data[w_nxt.bit_idx];
            r_shift   <= w_nxt.shift;
            r_idx     <= w_nxt.bit_idx;
            r_per     <= w_nper;
            r_cnt     <= CW'(1);
          end else begin
            if (r_cnt == HALF) begin
              jtag_tck <= 1'b1;
              if (r_shift) r_cap[r_idx] <= jtag_tdo;
            end
            r_cnt <= r_cnt + CW'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jtag_host.sv
// Bench for jtag_host: drives commands into a behavioural IEEE 1149.1 TAP
// (IR 4 bits, IDCODE/USER/BYPASS) and checks responses, pin sequences and timing.
module tb_jtag_host;

  localparam int unsigned CLK_DIV    = 2;
  localparam logic [31:0] IDCODE_VAL = {4'h1, 16'h2345, 11'h0AB, 1'b1};
  localparam logic [3:0]  IR_IDCODE  = 4'h1;
  localparam logic [3:0]  IR_USER    = 4'h8;
  localparam logic [3:0]  IR_BYPASS  = 4'hF;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_type = '0;
  logic [4:0]  cmd_len = '0;
  logic [31:0] cmd_data = '0;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        jtag_tck, jtag_tms, jtag_tdi, jtag_trst;
  logic        jtag_tdo = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  jtag_host #(.CLK_DIV(CLK_DIV)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_type(cmd_type),
    .cmd_len(cmd_len), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .jtag_tck(jtag_tck), .jtag_tms(jtag_tms), .jtag_tdi(jtag_tdi),
    .jtag_trst(jtag_trst), .jtag_tdo(jtag_tdo)
  );

  // ---------------- target TAP ----------------
  typedef enum logic [3:0] {TLR, RTI, SELDR, CAPDR, SHDR, EX1DR, PADR, EX2DR, UPDR,
                            SELIR, CAPIR, SHIR, EX1IR, PAIR, EX2IR, UPIR} tap_t;
  tap_t        tap_state = TLR;
  logic [3:0]  tap_ir = IR_IDCODE;
  logic [3:0]  tap_ir_sr = '0;
  logic [31:0] tap_dr_sr = '0;
  logic [31:0] tap_user_in = '0;
  logic [31:0] tap_user_out = '0;

  function automatic tap_t tap_next(tap_t s, logic m);
    case (s)
      TLR:     return m ? TLR   : RTI;
      RTI:     return m ? SELDR : RTI;
      SELDR:   return m ? SELIR : CAPDR;
      CAPDR:   return m ? EX1DR : SHDR;
      SHDR:    return m ? EX1DR : SHDR;
      EX1DR:   return m ? UPDR  : PADR;
      PADR:    return m ? EX2DR : PADR;
      EX2DR:   return m ? UPDR  : SHDR;
      UPDR:    return m ? SELDR : RTI;
      SELIR:   return m ? TLR   : CAPIR;
      CAPIR:   return m ? EX1IR : SHIR;
      SHIR:    return m ? EX1IR : SHIR;
      EX1IR:   return m ? UPIR  : PAIR;
      PAIR:    return m ? EX2IR : PAIR;
      EX2IR:   return m ? UPIR  : SHIR;
      default: return m ? SELDR : RTI;
    endcase
  endfunction

  always @(posedge jtag_tck or negedge jtag_trst) begin
    if (!jtag_trst) begin
      tap_state <= TLR;
      tap_ir    <= IR_IDCODE;
    end else begin
      case (tap_state)
        TLR:   tap_ir <= IR_IDCODE;
        CAPDR: tap_dr_sr <= (tap_ir == IR_IDCODE) ? IDCODE_VAL :
                            (tap_ir == IR_USER)   ? tap_user_in : 32'd0;
        SHDR:  if (tap_ir == IR_IDCODE || tap_ir == IR_USER)
                 tap_dr_sr <= {jtag_tdi, tap_dr_sr[31:1]};
               else
                 tap_dr_sr[0] <= jtag_tdi;
        UPDR:  if (tap_ir == IR_USER) tap_user_out <= tap_dr_sr;
        CAPIR: tap_ir_sr <= 4'b0001;
        SHIR:  tap_ir_sr <= {jtag_tdi, tap_ir_sr[3:1]};
        UPIR:  tap_ir <= tap_ir_sr;
        default: ;
      endcase
      tap_state <= tap_next(tap_state, jtag_tms);
    end
  end

  // Outside shift states TDO is random noise that must never reach rsp_data.
  always @(negedge jtag_tck) begin
    if (tap_state == SHDR)      jtag_tdo <= tap_dr_sr[0];
    else if (tap_state == SHIR) jtag_tdo <= tap_ir_sr[0];
    else                        jtag_tdo <= 1'($urandom);
  end

  // ---------------- monitors ----------------
  int   rises = 0;
  int   rsp_pulses = 0;
  logic q_tms[$];
  logic q_tdi[$];
  logic q_trst[$];

  always @(posedge jtag_tck) begin
    rises++;
    q_tms.push_back(jtag_tms);
    q_tdi.push_back(jtag_tdi);
    q_trst.push_back(jtag_trst);
  end

  always @(negedge clk) if (rsp_valid === 1'b1) rsp_pulses++;

  task automatic clear_mon();
    rises = 0;
    rsp_pulses = 0;
    q_tms.delete();
    q_tdi.delete();
    q_trst.delete();
  endtask

  function automatic logic [63:0] pack_q(int which);
    logic [63:0] v = '0;
    for (int i = 0; i < q_tms.size() && i < 64; i++)
      v[i] = (which == 0) ? q_tms[i] : (which == 1) ? q_tdi[i] : q_trst[i];
    return v;
  endfunction

  // ---------------- reference model ----------------
  logic [3:0] m_ir = IR_IDCODE;

  function automatic logic [31:0] len_mask(int n);
    logic [63:0] m;
    m = (64'd1 << n) - 64'd1;
    return m[31:0];
  endfunction

  function automatic int periods(int t, int n);
    case (t)
      0:       return 6;
      1:       return n + 6;
      2:       return n + 5;
      default: return n;
    endcase
  endfunction

  function automatic int exp_lat(int t, int n);
    return periods(t, n) * 2 * CLK_DIV + 1;
  endfunction

  function automatic logic [31:0] exp_dr(logic [3:0] ir, int n, logic [31:0] d, logic [31:0] uin);
    if (ir == IR_IDCODE) return IDCODE_VAL & len_mask(n);
    if (ir == IR_USER)   return uin & len_mask(n);
    return {d[30:0], 1'b0} & len_mask(n);
  endfunction

  function automatic logic [31:0] exp_ir(int n, logic [31:0] d);
    return {d[27:0], 4'b0001} & len_mask(n);
  endfunction

  // ---------------- driver ----------------
  task automatic do_cmd(input logic [1:0] t, input logic [4:0] l, input logic [31:0] d,
                        output logic [31:0] rsp, output int lat);
    int w = 0;
    cmd_type = t; cmd_len = l; cmd_data = d; cmd_valid = 1'b1;
    while (cmd_ready !== 1'b1 && w < 300) begin @(negedge clk); w++; end
    clear_mon();
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_type = 2'($urandom); cmd_len = 5'($urandom); cmd_data = $urandom;
    lat = 0;
    while (rsp_valid !== 1'b1 && lat < 400) begin @(negedge clk); lat++; end
    rsp = rsp_data;
    if (rsp_valid !== 1'b1) begin
      checks++; errors++;
      $display("FAIL cmd_timeout: rsp_valid=%b required 1 (type %0d len %0d)", rsp_valid, t, l);
    end
  endtask

  task automatic wait_ready(output int c);
    c = 0;
    while (cmd_ready !== 1'b1 && c < 300) begin @(negedge clk); c++; end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int c;
    repeat (3) @(negedge clk);
    checks++;
    if ({jtag_tck, jtag_tms, jtag_tdi, jtag_trst, cmd_ready, rsp_valid} !== 6'b010000 || rsp_data !== '0) begin
      errors++;
      $display("FAIL reset_values: tck/tms/tdi/trst/rdy/vld=%b rsp=%h required 010000 0",
               {jtag_tck, jtag_tms, jtag_tdi, jtag_trst, cmd_ready, rsp_valid}, rsp_data);
    end
    clear_mon();
    rst = 1'b1;
    wait_ready(c);
    checks++;
    if (c != 6 * 2 * CLK_DIV + 1) begin
      errors++; $display("FAIL autorst_ready_clk: got %0d required %0d", c, 6 * 2 * CLK_DIV + 1);
    end
    checks++;
    if (rises != 6) begin errors++; $display("FAIL autorst_rises: got %0d required 6", rises); end
    checks++;
    if (pack_q(2) !== 64'b100000 || pack_q(0) !== 64'b011111) begin
      errors++; $display("FAIL autorst_trst_tms: trst=%b tms=%b required 100000 011111",
                         pack_q(2), pack_q(0));
    end
    checks++;
    if (rsp_pulses != 0) begin errors++; $display("FAIL autorst_rsp: got %0d pulses required 0", rsp_pulses); end
    checks++;
    if ({jtag_tck, jtag_tms, jtag_tdi, jtag_trst} !== 4'b0001) begin
      errors++; $display("FAIL idle_pins: got %b required 0001", {jtag_tck, jtag_tms, jtag_tdi, jtag_trst});
    end
    m_ir = IR_IDCODE;
  endtask

  task automatic test_idcode();
    logic [31:0] r; int lat;
    do_cmd(2'd2, 5'd31, 32'd0, r, lat);
    checks++;
    if (r !== exp_dr(m_ir, 32, 0, 0)) begin errors++; $display("FAIL idcode: got %h required %h", r, IDCODE_VAL); end
    checks++;
    if (lat != exp_lat(2, 32)) begin errors++; $display("FAIL idcode_lat: got %0d required %0d", lat, exp_lat(2, 32)); end
  endtask

  task automatic test_user_reg();
    logic [31:0] r; int lat;
    tap_user_in = 32'h0BADF00D;
    do_cmd(2'd1, 5'd3, 32'h8, r, lat);
    m_ir = IR_USER;
    checks++;
    if (r !== 32'h1) begin errors++; $display("FAIL ir_capture: got %h required 00000001", r); end
    do_cmd(2'd2, 5'd31, 32'hDEADBEEF, r, lat);
    checks++;
    if (r !== 32'h0BADF00D) begin errors++; $display("FAIL user_capture: got %h required 0badf00d", r); end
    checks++;
    if (tap_user_out !== 32'hDEADBEEF) begin
      errors++; $display("FAIL user_update: got %h required deadbeef", tap_user_out);
    end
  endtask

  task automatic test_bypass();
    logic [31:0] r; int lat;
    do_cmd(2'd1, 5'd3, 32'hF, r, lat);
    m_ir = IR_BYPASS;
    do_cmd(2'd2, 5'd7, 32'hA5, r, lat);
    checks++;
    if (r !== 32'h4A) begin errors++; $display("FAIL bypass: got %h required 0000004a", r); end
  endtask

  task automatic test_dr_len0();
    logic [31:0] r; int lat;
    do_cmd(2'd2, 5'd0, 32'hFFFFFFFF, r, lat);
    checks++;
    if (rises != 6) begin errors++; $display("FAIL len0_rises: got %0d required 6", rises); end
    checks++;
    if (pack_q(0) !== 64'b011001) begin errors++; $display("FAIL len0_tms: got %b required 011001", pack_q(0)); end
    checks++;
    if (pack_q(1) !== 64'b001000) begin errors++; $display("FAIL len0_tdi: got %b required 001000", pack_q(1)); end
    checks++;
    if (lat != 25) begin errors++; $display("FAIL len0_lat: got %0d required 25", lat); end
    checks++;
    if (r !== exp_dr(m_ir, 1, 32'hFFFFFFFF, tap_user_in)) begin
      errors++; $display("FAIL len0_rsp: got %h required %h", r, exp_dr(m_ir, 1, 32'hFFFFFFFF, tap_user_in));
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] r; int lat; int c;
    do_cmd(2'd2, 5'd0, 32'd0, r, lat);
    checks++;
    if (cmd_ready !== 1'b1) begin errors++; $display("FAIL done_ready: got %b required 1", cmd_ready); end
    cmd_type = 2'd3; cmd_len = 5'd1; cmd_data = 32'd0; cmd_valid = 1'b1;
    clear_mon();
    @(negedge clk);
    cmd_valid = 1'b0;
    checks++;
    if ({cmd_ready, rsp_valid} !== 2'b00) begin
      errors++; $display("FAIL b2b_accept: rdy/vld=%b required 00", {cmd_ready, rsp_valid});
    end
    c = 0;
    while (jtag_tck !== 1'b1 && c < 50) begin @(negedge clk); c++; end
    checks++;
    if (c != 1 + CLK_DIV) begin errors++; $display("FAIL b2b_first_rise: got %0d required %0d", c, 1 + CLK_DIV); end
    while (rsp_valid !== 1'b1 && c < 100) begin @(negedge clk); c++; end
    checks++;
    if (c != exp_lat(3, 2)) begin errors++; $display("FAIL b2b_lat: got %0d required %0d", c, exp_lat(3, 2)); end
    checks++;
    if (rsp_data !== 32'd0) begin errors++; $display("FAIL b2b_rsp: got %h required 0", rsp_data); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] r; int lat; int c;
    wait_ready(c);
    cmd_type = 2'd1; cmd_len = 5'd3; cmd_data = 32'hF; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (20) @(negedge clk);
    clear_mon();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({jtag_tck, jtag_tms, jtag_tdi, jtag_trst, cmd_ready, rsp_valid} !== 6'b010000 || rsp_data !== '0) begin
      errors++;
      $display("FAIL midrst_values: pins=%b rsp=%h required 010000 0",
               {jtag_tck, jtag_tms, jtag_tdi, jtag_trst, cmd_ready, rsp_valid}, rsp_data);
    end
    rst = 1'b1;
    wait_ready(c);
    checks++;
    if (c != 6 * 2 * CLK_DIV + 1) begin errors++; $display("FAIL midrst_ready_clk: got %0d required 25", c); end
    checks++;
    if (rsp_pulses != 0) begin errors++; $display("FAIL midrst_rsp: got %0d pulses required 0", rsp_pulses); end
    m_ir = IR_IDCODE;
    do_cmd(2'd2, 5'd31, 32'd0, r, lat);
    checks++;
    if (r !== IDCODE_VAL) begin errors++; $display("FAIL midrst_idcode: got %h required %h", r, IDCODE_VAL); end
  endtask

  task automatic test_runtest();
    logic [31:0] r; int lat;
    do_cmd(2'd3, 5'd31, 32'hFFFFFFFF, r, lat);
    checks++;
    if (rises != 32) begin errors++; $display("FAIL rti_rises: got %0d required 32", rises); end
    checks++;
    if (pack_q(0) !== '0 || pack_q(1) !== '0) begin
      errors++; $display("FAIL rti_pins: tms=%h tdi=%h required 0 0", pack_q(0), pack_q(1));
    end
    checks++;
    if (r !== '0) begin errors++; $display("FAIL rti_rsp: got %h required 0", r); end
    checks++;
    if (lat != exp_lat(3, 32)) begin errors++; $display("FAIL rti_lat: got %0d required %0d", lat, exp_lat(3, 32)); end
  endtask

  task automatic test_random();
    logic [31:0] r, d, e, uo;
    logic [3:0]  code;
    int lat, n, op;
    for (int it = 0; it < 16; it++) begin
      op = int'($urandom_range(0, 3));
      d  = $urandom;
      case (op)
        0: begin
          n = int'($urandom_range(1, 32));
          do_cmd(2'd0, 5'(n - 1), d, r, lat);
          m_ir = IR_IDCODE;
          e = '0;
          checks++;
          if (pack_q(2) !== 64'b100000) begin
            errors++; $display("FAIL rnd_trst_seq: got %b required 100000", pack_q(2));
          end
          n = 6;
        end
        1: begin
          n = int'($urandom_range(4, 32));
          case ($urandom_range(0, 3))
            0:       code = IR_IDCODE;
            1:       code = IR_USER;
            2:       code = IR_BYPASS;
            default: code = 4'($urandom);
          endcase
          d = (d & len_mask(n - 4)) | ({28'd0, code} << (n - 4));
          e = exp_ir(n, d);
          do_cmd(2'd1, 5'(n - 1), d, r, lat);
          m_ir = code;
        end
        2: begin
          n = int'($urandom_range(1, 32));
          tap_user_in = $urandom;
          e = exp_dr(m_ir, n, d, tap_user_in);
          uo = (d << (32 - n)) | (tap_user_in >> n);
          do_cmd(2'd2, 5'(n - 1), d, r, lat);
          if (m_ir == IR_USER) begin
            checks++;
            if (tap_user_out !== uo) begin
              errors++; $display("FAIL rnd_user_update: got %h required %h (n=%0d)", tap_user_out, uo, n);
            end
          end
        end
        default: begin
          n = int'($urandom_range(1, 32));
          e = '0;
          do_cmd(2'd3, 5'(n - 1), d, r, lat);
        end
      endcase
      checks++;
      if (r !== e) begin errors++; $display("FAIL rnd_rsp: op %0d n %0d got %h required %h", op, n, r, e); end
      checks++;
      if (lat != exp_lat(op, n)) begin
        errors++; $display("FAIL rnd_lat: op %0d n %0d got %0d required %0d", op, n, lat, exp_lat(op, n));
      end
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_idcode();
    test_user_reg();
    test_bypass();
    test_dr_len0();
    test_back_to_back();
    test_reset_mid();
    test_runtest();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
